fetch_refill: RTL
=================

# fetch_refill

Parametrised instruction-cache refill engine for the fetch stage. On a miss it issues one AXI4 read burst for a whole line and forwards the critical word as soon as its beat arrives. It assembles the line and presents it to the cache write port in a single pulse. It supports configurable line length, INCR or WRAP (critical-word-first) bursts, flush-abort with beat draining, and response-error reporting.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per line; legal values 2, 4, 8, 16.
- WRAP, 1: 1 issues a WRAP burst from the missing word; 0 issues an INCR burst from the line base.
- AXI_ID, 0: constant driven on arid_o.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  miss request.
- req_ready_o  out  1  high only in IDLE.
- req_addr_i  in  32  missing instruction address; bits [1:0] are ignored.
- flush_i  in  1  aborts the outstanding refill.
- crit_valid_o  out  1  one-cycle pulse when the critical word is available.
- crit_inst_o  out  32  critical word.
- fill_valid_o  out  1  one-cycle line write pulse.
- fill_addr_o  out  32  line-aligned address.
- fill_data_o  out  32*LINE_WORDS  line data; word i sits at bits [32i+31:32i].
- fill_err_o  out  1  some beat had rresp != 0, or rlast arrived early.
- arvalid_o, arready_i, araddr_o[31:0], arid_o[3:0], arlen_o[7:0], arsize_o[2:0], arburst_o[1:0]: AXI AR channel.
- rvalid_i, rready_o, rdata_i[31:0], rresp_i[1:0], rlast_i, rid_i[3:0]: AXI R channel. rid_i is not checked.

## Operation
States:
- IDLE: req_ready_o=1. On req_valid_i, latch the address → AR.
- AR: arvalid_o=1 until arready_i. On handshake → RDATA, or → DRAIN if a flush is pending.
- RDATA: rready_o=1. Each beat stores word at index idx=(start+cnt) mod LINE_WORDS and increments cnt. On rlast_i → FILL.
- FILL: fill_valid_o=1 for one cycle → IDLE.
- DRAIN: rready_o=1. Data is discarded. On rlast_i → IDLE. No fill, no crit.

Address generation:
- start = req_addr_i[2+:log2(LINE_WORDS)].
- WRAP=1: araddr_o is word-aligned at the missing word, arburst_o=2'b10.
- WRAP=0: araddr_o is line-aligned, arburst_o=2'b01, start is treated as 0 for idx while the critical index remains the original offset.
- arlen_o=LINE_WORDS-1, arsize_o=3'b010, arid_o=AXI_ID.

Outputs:
- crit_valid_o pulses in the cycle after the accepted beat whose idx equals the original offset, unless a flush occurred at or before that beat. With WRAP=1 this is always the first beat.
- fill_err_o is sticky per refill: set by any rresp_i != 0, or by rlast_i arriving with cnt != LINE_WORDS-1. It is cleared on request acceptance. The FILL pulse is still issued with fill_err_o=1, and the consumer must not mark the line valid.

Flush:
- IDLE or FILL: no effect; an in-progress fill pulse still completes.
- AR: arvalid_o stays high (AXI rule) and a pending flag is set. After the handshake → DRAIN.
- RDATA: → DRAIN next cycle; the flush beat is consumed but dropped. If rlast_i occurs in the flush cycle → IDLE directly with no FILL.
- A request presented together with a flush in IDLE is accepted normally.

## Timing
- Reset values: state=IDLE, req_ready_o=1, arvalid_o=0, rready_o=0, crit_valid_o=0, fill_valid_o=0, fill_err_o=0, all data/addr registers 0. AR static fields are constant.
- Request accepted at cycle 0. arvalid_o is high from cycle 1.
- AR handshake at cycle 1 → first beat can be accepted at cycle 2.
- Last of N beats at cycle 1+N → fill_valid_o at cycle 2+N. req_ready_o returns at 3+N.
- Minimum latency for LINE_WORDS=4, WRAP=1, zero-wait slave: crit at cycle 3, fill at cycle 6.
- Every output is registered. No combinational path from any AXI input to arvalid_o, rready_o, or the fill/crit outputs.
- Reset may assert mid-burst. Recovery is the system's responsibility; the block simply returns to IDLE.

## Structure
- Shared package fetch_pkg holds:
  - state encoding (IDLE, AR, RDATA, FILL, DRAIN)
  - AXI constants BURST_INCR=2'b01, BURST_WRAP=2'b10, RESP_OKAY=2'b00, SIZE_WORD=3'b010
- One sub-module, fetch_refill_buf: an LINE_WORDS×32 line register with an indexed write enable and per-refill clear. The FSM, counters, and AR logic stay in fetch_refill.

## Test plan
- WRAP=1, LINE_WORDS=4, req 0x8000_0008, zero-wait slave, beats D2,D3,D0,D1 → araddr 0x8000_0008, arlen 3, arburst 2'b10; crit D2 at cycle 3; fill addr 0x8000_0000, data {D3,D2,D1,D0}, err 0 at cycle 6.
- WRAP=0, LINE_WORDS=8, req 0x8000_001C → araddr 0x8000_0000, arburst 2'b01; crit pulse follows beat 7 only; fill after 8 beats.
- arready_i held low 5 cycles with flush_i pulsed in the 2nd → arvalid_o stays high until the handshake; all 4 beats drained with rready_o=1; no crit, no fill; req_ready_o=1 after rlast.
- Flush on beat 2 of 4 in RDATA → crit already delivered for beat 0; beats 2–3 dropped; no fill_valid_o.
- rresp_i=2'b10 on beat 1, or rlast_i on beat 2 of 4 → fill_valid_o pulses with fill_err_o=1; next request clears the error.
- Reset deasserted then asserted during RDATA → all outputs return to their reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch refill engine: FSM states and
// the AXI4 field constants it drives or compares against.
package fetch_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_AR    = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_FILL  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

endpackage

// File: rtl/fetch_refill_buf.sv
// Line assembly register: LINE_WORDS x 32-bit words, one indexed word write
// per cycle, cleared as a whole at the start of each refill.
module fetch_refill_buf #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [31:0]             wr_data,
    output logic [32*LINE_WORDS-1:0] line
);

    logic [31:0] words [LINE_WORDS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
        assign line[32*g +: 32] = words[g];
    end

endmodule

// File: rtl/fetch_refill.sv
// Instruction-cache refill engine: one AXI4 read burst per miss, critical
// word forwarded early, whole line written to the cache in a single pulse.
module fetch_refill
    import fetch_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter bit         WRAP       = 1'b1,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_addr_i,
    input  logic                     flush_i,
    output logic                     crit_valid_o,
    output logic [31:0]              crit_inst_o,
    output logic                     fill_valid_o,
    output logic [31:0]              fill_addr_o,
    output logic [32*LINE_WORDS-1:0] fill_data_o,
    output logic                     fill_err_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    output logic [31:0]              araddr_o,
    output logic [3:0]               arid_o,
    output logic [7:0]               arlen_o,
    output logic [2:0]               arsize_o,
    output logic [1:0]               arburst_o,
    input  logic                     rvalid_i,
    output logic                     rready_o,
    input  logic [31:0]              rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     rlast_i,
    input  logic [3:0]               rid_i,
    output logic [2:0]               dbg_state_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    // Handshakes: a transfer happens on a cycle where both valid and ready
    // are high; once raised, arvalid_o holds until arready_i (flush included).

    logic [2:0]       state;
    logic             flush_pend;
    logic [IDX_W-1:0] start_q;
    logic [IDX_W-1:0] crit_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      araddr_q;
    logic [31:0]      fill_addr_q;
    logic             err_q;
    logic             crit_valid_q;
    logic [31:0]      crit_inst_q;

    logic [IDX_W-1:0] req_off;
    logic [31:0]      req_line;
    logic [IDX_W-1:0] beat_idx;
    logic             accept;
    logic             store;
    logic             unused_ok;

    assign req_off  = req_addr_i[2 +: IDX_W];
    assign req_line = {req_addr_i[31:2+IDX_W], {(2+IDX_W){1'b0}}};
    assign beat_idx = start_q + cnt_q[IDX_W-1:0];
    assign accept   = (state == ST_IDLE) && req_valid_i;
    assign store    = (state == ST_RDATA) && rvalid_i && !flush_i;
    assign unused_ok = ^{rid_i, req_addr_i[1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            flush_pend   <= 1'b0;
            start_q      <= '0;
            crit_idx_q   <= '0;
            cnt_q        <= '0;
            araddr_q     <= '0;
            fill_addr_q  <= '0;
            err_q        <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_inst_q  <= '0;
        end else begin
            crit_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        araddr_q    <= WRAP ? {req_addr_i[31:2], 2'b00} : req_line;
                        fill_addr_q <= req_line;
                        start_q     <= WRAP ? req_off : '0;
                        crit_idx_q  <= req_off;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        flush_pend  <= 1'b0;
                        state       <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (flush_i) flush_pend <= 1'b1;
                    if (arready_i) state <= (flush_pend || flush_i) ? ST_DRAIN : ST_RDATA;
                end
                ST_RDATA: begin
                    // A flush beat is consumed but never stored or forwarded.
                    if (flush_i) begin
                        state <= (rvalid_i && rlast_i) ? ST_IDLE : ST_DRAIN;
                    end else if (rvalid_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (beat_idx == crit_idx_q) begin
                            crit_valid_q <= 1'b1;
                            crit_inst_q  <= rdata_i;
                        end
                        if (rresp_i != RESP_OKAY || (rlast_i && cnt_q != LAST_CNT))
                            err_q <= 1'b1;
                        if (rlast_i) state <= ST_FILL;
                    end
                end
                ST_FILL:  state <= ST_IDLE;
                ST_DRAIN: if (rvalid_i && rlast_i) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    fetch_refill_buf #(.LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W)) u_buf (
        .clock   (clock),
        .reset   (reset),
        .clr     (accept),
        .wr_en   (store),
        .wr_idx  (beat_idx),
        .wr_data (rdata_i),
        .line    (fill_data_o)
    );

    assign req_ready_o  = (state == ST_IDLE);
    assign arvalid_o    = (state == ST_AR);
    assign rready_o     = (state == ST_RDATA) || (state == ST_DRAIN);
    assign fill_valid_o = (state == ST_FILL);
    assign fill_addr_o  = fill_addr_q;
    assign fill_err_o   = err_q;
    assign crit_valid_o = crit_valid_q;
    assign crit_inst_o  = crit_inst_q;
    assign araddr_o     = araddr_q;
    assign arid_o       = AXI_ID;
    assign arlen_o      = 8'(LINE_WORDS - 1);
    assign arsize_o     = SIZE_WORD;
    assign arburst_o    = WRAP ? BURST_WRAP : BURST_INCR;
    assign dbg_state_o  = state;

endmodule
